// File: rtl/input_handshake.sv
// Load-button input stage: synchronises switches and button, debounces the
// press, and hands one captured word per press to the cpu via valid/ack.
module input_handshake #(
    parameter int N               = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] sw,
    input  logic         button,
    input  logic         ack,
    output logic [N-1:0] data,
    output logic         valid
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        VALID   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    logic [N-1:0]  r_sw_meta;
    logic [N-1:0]  r_sw_sync;
    logic          r_btn_meta;
    logic          r_btn_sync;
    state_t        r_state;
    logic [CW-1:0] r_count;
    logic [N-1:0]  r_data;
    logic          r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
            r_btn_meta <= 1'b0;
            r_btn_sync <= 1'b0;
        end else begin
            r_sw_meta  <= sw;
            r_sw_sync  <= r_sw_meta;
            r_btn_meta <= button;
            r_btn_sync <= r_btn_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (r_btn_sync) begin
                        r_state <= PRESS;
                        r_count <= CW'(1);
                    end else begin
                        r_count <= '0;
                    end
                end
                PRESS: begin
                    if (!r_btn_sync) begin
                        r_state <= IDLE;
                        r_count <= '0;
                    end else if (r_count < CMAX) begin
                        r_count <= r_count + CW'(1);
                    end else begin
                        r_data  <= r_sw_sync;
                        r_valid <= 1'b1;
                        r_state <= VALID;
                    end
                end
                VALID: begin
                    // Button level is deliberately ignored until the cpu acks.
                    if (ack) begin
                        r_valid <= 1'b0;
                        r_state <= RELEASE;
                        r_count <= '0;
                    end
                end
                RELEASE: begin
                    if (r_btn_sync) begin
                        r_count <= '0;
                    end else if (r_count < CMAX) begin
                        r_count <= r_count + CW'(1);
                    end else begin
                        r_state <= IDLE;
                        r_count <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_count <= '0;
                end
            endcase
        end
    end

    assign data  = r_data;
    assign valid = r_valid;

endmodule

// File: tb/tb_input_handshake.sv
// Directed bench for input_handshake with N=8, D=4.
module tb_input_handshake;

    localparam int N = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] sw;
    logic         button;
    logic         ack;
    logic [N-1:0] data;
    logic         valid;

    int checks   = 0;
    int failures = 0;
    int hi;

    input_handshake #(
        .N(N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw(sw),
        .button(button),
        .ack(ack),
        .data(data),
        .valid(valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic count_valid(input int n, output int h);
        h = 0;
        repeat (n) begin
            tick(1);
            if (valid === 1'b1) h++;
        end
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        sw     = '0;
        button = 1'b0;
        ack    = 1'b0;
        tick(2);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_data", 32'(data), 32'h00);
        rst = 1'b0;
        tick(2);

        // clean press
        sw     = 8'hA5;
        button = 1'b1;
        count_valid(6, hi);
        chk("clean_early", hi, 0);
        tick(1);
        chk("clean_valid", 32'(valid), 32'd1);
        chk("clean_data", 32'(data), 32'hA5);
        ack_pulse();
        chk("clean_ack_valid", 32'(valid), 32'd0);
        chk("clean_ack_data", 32'(data), 32'hA5);
        button = 1'b0;
        tick(10);

        // bounce: 3 high, 1 low, then high
        sw     = 8'h5A;
        button = 1'b1;
        count_valid(3, hi);
        chk("bounce_a", hi, 0);
        button = 1'b0;
        count_valid(1, hi);
        chk("bounce_b", hi, 0);
        button = 1'b1;
        count_valid(6, hi);
        chk("bounce_c", hi, 0);
        tick(1);
        chk("bounce_valid", 32'(valid), 32'd1);
        chk("bounce_data", 32'(data), 32'h5A);
        ack_pulse();
        count_valid(20, hi);
        chk("bounce_single", hi, 0);
        button = 1'b0;
        tick(10);

        // hold with frozen data
        sw     = 8'hA5;
        button = 1'b1;
        tick(7);
        chk("hold_valid", 32'(valid), 32'd1);
        sw = 8'h3C;
        tick(3);
        chk("hold_still", 32'(valid), 32'd1);
        chk("hold_frozen", 32'(data), 32'hA5);
        ack_pulse();
        chk("hold_ack", 32'(valid), 32'd0);
        count_valid(20, hi);
        chk("hold_no_second", hi, 0);
        button = 1'b0;
        count_valid(7, hi);
        chk("hold_release", hi, 0);
        button = 1'b1;
        count_valid(6, hi);
        chk("hold_repress_early", hi, 0);
        tick(1);
        chk("hold_repress_valid", 32'(valid), 32'd1);
        chk("hold_repress_data", 32'(data), 32'h3C);
        ack_pulse();
        button = 1'b0;
        tick(10);

        // ack misuse
        ack = 1'b1;
        count_valid(5, hi);
        chk("ack_idle", hi, 0);
        sw     = 8'h11;
        button = 1'b1;
        count_valid(6, hi);
        chk("ackhi1_early", hi, 0);
        tick(1);
        chk("ackhi1_valid", 32'(valid), 32'd1);
        chk("ackhi1_data", 32'(data), 32'h11);
        count_valid(10, hi);
        chk("ackhi1_width", hi, 0);
        button = 1'b0;
        tick(10);
        sw     = 8'h22;
        button = 1'b1;
        count_valid(6, hi);
        chk("ackhi2_early", hi, 0);
        tick(1);
        chk("ackhi2_valid", 32'(valid), 32'd1);
        chk("ackhi2_data", 32'(data), 32'h22);
        count_valid(10, hi);
        chk("ackhi2_width", hi, 0);
        ack    = 1'b0;
        button = 1'b0;
        tick(10);

        // release glitch, re-press after only 4 lows
        sw     = 8'h77;
        button = 1'b1;
        tick(7);
        chk("glitchA_valid", 32'(valid), 32'd1);
        ack_pulse();
        button = 1'b0;
        tick(3);
        button = 1'b1;
        tick(1);
        button = 1'b0;
        tick(4);
        button = 1'b1;
        count_valid(20, hi);
        chk("glitchA_no_capture", hi, 0);
        button = 1'b0;
        tick(10);

        // release glitch, then 5 lows reaches idle
        sw     = 8'h99;
        button = 1'b1;
        tick(7);
        chk("glitchB_valid", 32'(valid), 32'd1);
        chk("glitchB_data", 32'(data), 32'h99);
        ack_pulse();
        button = 1'b0;
        tick(3);
        button = 1'b1;
        tick(1);
        button = 1'b0;
        tick(5);
        sw     = 8'h66;
        button = 1'b1;
        count_valid(6, hi);
        chk("glitchB_early", hi, 0);
        tick(1);
        chk("glitchB_press", 32'(valid), 32'd1);
        chk("glitchB_press_data", 32'(data), 32'h66);
        ack_pulse();
        button = 1'b0;
        tick(10);

        // async reset mid-VALID
        sw     = 8'hC3;
        button = 1'b1;
        tick(7);
        chk("rstmid_valid", 32'(valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_valid0", 32'(valid), 32'd0);
        chk("rstmid_data0", 32'(data), 32'h00);
        #2;
        rst = 1'b0;
        count_valid(6, hi);
        chk("rstmid_early", hi, 0);
        tick(1);
        chk("rstmid_repress", 32'(valid), 32'd1);
        chk("rstmid_data", 32'(data), 32'hC3);
        ack_pulse();
        button = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/input_handshake.md
# input_handshake

Upstream input stage for the picoMIPS cpu. It synchronises the raw board data switches and the load push-button, debounces the button, and captures one N-bit data word per press. It presents that word to the cpu with a valid/ack handshake. It guarantees exactly one word per physical press, regardless of how long the button is held or how it bounces.

## Interface

**Parameters**
- N, 8, data width; matches the cpu data bus width.
- DEBOUNCE_CYCLES, 16, stability count D; the button must be stable for D+1 consecutive synchronised samples. Legal range is D ≥ 1.

**Ports**
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- sw  in  N  raw, asynchronous data switches.
- button  in  1  raw, asynchronous load button; 1 = pressed.
- ack  in  1  cpu has consumed data; sampled only in VALID.
- data  out  N  captured word; registered.
- valid  out  1  data is available; registered.

## Operation

- **Synchronisers**
  - sw and button each pass through 2 flip-flop stages, giving swSync and btnSync.
  - Synchroniser flops reset to 0.
- **Debounce counter**
  - Width is $clog2(D+1) bits.
  - Resets to 0.
  - Never exceeds D; no wrap-around.
- **State machine states:** IDLE, PRESS, VALID, RELEASE. Reset state is IDLE.
- **IDLE**
  - btnSync=1: go to PRESS, count=1.
  - Otherwise stay in IDLE, count=0.
- **PRESS**
  - btnSync=0: go to IDLE, count=0. This is a bounce; the press is discarded.
  - btnSync=1 and count<D: count++.
  - btnSync=1 and count==D: capture data<=swSync, set valid<=1, go to VALID.
- **VALID**
  - valid=1 throughout; data is frozen.
  - ack=1: set valid<=0, go to RELEASE, count=0.
  - The button level is ignored in this state. Releasing before ack keeps valid high.
- **RELEASE**
  - btnSync=1: count=0.
  - btnSync=0 and count<D: count++.
  - btnSync=0 and count==D: go to IDLE.
  - No new capture is possible until IDLE is reached.
- **ack handling**
  - ack is ignored in IDLE, PRESS and RELEASE.
  - ack held permanently high makes valid last exactly 1 cycle per press.
- **data**
  - data changes only on the capture edge.
  - data holds its last value after ack, until the next capture.
- **Reset**
  - Reset asserted in any state, including mid-PRESS and mid-VALID, immediately forces:
    - state=IDLE
    - valid=0
    - data=0
    - count=0
    - synchroniser flops=0
  - The first press after reset release follows the normal IDLE path.

## Timing

- **Reset values:** valid=0, data={N{1'b0}}.
- **Press latency**
  - Call edge 1 the first clk edge at which button is sampled high.
  - If button stays high, valid rises after edge D+3. For D=4, valid is high after edge 7.
  - data equals the sw value sampled at edge D+1.
- **Handshake**
  - ack is sampled on the edge. valid falls after the first edge at which valid=1 and ack=1.
  - Minimum valid width is 1 cycle.
- **Release**
  - RELEASE→IDLE requires D+1 consecutive btnSync=0 samples.
  - Any high sample restarts the count.
- **Minimum press-to-press spacing:** 2(D+1) synchronised samples, plus the VALID dwell time.
- **Combinational paths:** none from inputs to outputs. Both outputs come directly from flops.

## Test plan

All scenarios use N=8, D=4.

- **Reset:**
  - rst=1 at time 0 → valid=0, data=0x00.
  - Reach VALID, then pulse rst mid-cycle → valid drops asynchronously before the next edge; data=0x00.
- **Clean press:**
  - sw=0xA5, button held high from edge 1 → valid=1 after edge 7, data=0xA5.
  - ack=1 for 1 cycle → valid=0 after that edge; data stays 0xA5.
- **Bounce:**
  - button high 3 samples, low 1, then high continuously → no valid during the bounce.
  - valid rises 7 edges after the final rising sample.
  - Exactly one capture occurs.
- **Hold and frozen data:**
  - Press, then change sw to 0x3C while valid=1 → data stays 0xA5.
  - ack while button still held → no second valid until button low ≥5 samples and pressed again.
  - The next capture gives 0x3C.
- **ack misuse:**
  - ack=1 in IDLE → no effect.
  - ack tied high for two separate presses → valid is exactly 1 cycle wide each time, with data 0x11 then 0x22.
- **Release glitch:**
  - In RELEASE, button low 3 samples, high 1, low 5 → IDLE is reached only after the 5 consecutive low samples.
  - A press before then is not captured.
